// File: rtl/mod_sched.sv
// rtl/mod_sched.sv - two-requester round-robin signed modular reducer (IDLE/RUN/DONE)
// Optional RUN-cycle counter output busy_cycles: define MOD_SCHED_BUSYCNT_EN
module mod_sched #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [7:0]        cfg_modulus,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_x,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_x,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  x_mod,
  output logic              res_id
`ifdef MOD_SCHED_BUSYCNT_EN
  ,
  output logic [15:0]       busy_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic signed [DATA_W:0] acc_q, acc_d;
  logic [7:0]             modulus_q, modulus_d;
  logic                   id_q, id_d;
  logic                   last_q, last_d;
  logic signed [DATA_W:0] mod_ext;
  logic                   grant1;
  logic [DATA_W-1:0]      x_sel;

  assign mod_ext = $signed({{(DATA_W - 7){1'b0}}, modulus_q});

  // Tie goes to the requester that was not granted last time.
  assign grant1 = req1_valid && (!req0_valid || !last_q);
  assign x_sel  = grant1 ? req1_x : req0_x;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    modulus_d  = modulus_q;
    id_d       = id_q;
    last_d     = last_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_we && (cfg_modulus >= 8'd1) && (cfg_modulus <= 8'd32))
          modulus_d = cfg_modulus;
        if (rst_n && (req0_valid || req1_valid)) begin
          req0_ready = !grant1;
          req1_ready = grant1;
          acc_d      = {x_sel[DATA_W-1], x_sel};
          id_d       = grant1;
          last_d     = grant1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (acc_q[DATA_W])
          acc_d = acc_q + mod_ext;
        else if (acc_q >= mod_ext)
          acc_d = acc_q - mod_ext;
        else
          state_d = DONE;
      end
      DONE: begin
        if (res_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      modulus_q <= 8'd17;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      modulus_q <= modulus_d;
      id_q      <= id_d;
      last_q    <= last_d;
    end
  end

  assign res_valid = (state_q == DONE);
  assign x_mod     = acc_q[RES_W-1:0];
  assign res_id    = id_q;

`ifdef MOD_SCHED_BUSYCNT_EN
  logic [15:0] busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy_q <= '0;
    else if ((state_q == RUN) && (busy_q != 16'hFFFF))
      busy_q <= busy_q + 16'd1;
  end

  assign busy_cycles = busy_q;
`endif

endmodule

// File: tb/tb_mod_sched.sv
// tb/tb_mod_sched.sv - scoreboard bench for mod_sched with randomized requesters
// Build with MOD_SCHED_BUSYCNT_EN to also check busy_cycles
module tb_mod_sched;
  localparam int DATA_W = 8;
  localparam int RES_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [7:0]        cfg_modulus = '0;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic [DATA_W-1:0] req0_x = '0, req1_x = '0;
  logic              req0_ready, req1_ready;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [RES_W-1:0]  x_mod;
  logic              res_id;
`ifdef MOD_SCHED_BUSYCNT_EN
  logic [15:0]       busy_cycles;
`endif

  mod_sched #(.DATA_W(DATA_W), .RES_W(RES_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_modulus(cfg_modulus),
    .req0_valid(req0_valid), .req0_x(req0_x), .req1_valid(req1_valid), .req1_x(req1_x),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .x_mod(x_mod), .res_id(res_id)
`ifdef MOD_SCHED_BUSYCNT_EN
    , .busy_cycles(busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int id; int xm; int lat; int acyc;} exp_t;
  exp_t sbq[$];

  int tests = 0, fails = 0;
  int m_mod = 17;
  int m_last = 1;
  int stall_req = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_mod(input int x, input int m);
    int r;
    r = x % m;
    if (r < 0) r += m;
    return r;
  endfunction

  // One cycle to enter RUN's final check plus one cycle per add/sub step.
  function automatic int ref_lat(input int x, input int m);
    if (x < 0) return 1 + (-x + m - 1) / m;
    return 1 + x / m;
  endfunction

  task automatic issue(input bit v0, input int x0, input bit v1, input int x1,
                       input bit we, input int wm, output int gid);
    int budget, eg, x;
    exp_t e;
    req0_valid = v0; req0_x = x0[7:0];
    req1_valid = v1; req1_x = x1[7:0];
    cfg_we = we; cfg_modulus = wm[7:0];
    budget = 0;
    #1;
    while (!(req0_ready || req1_ready) && budget < 3000) begin
      @(negedge clk); #1; budget++;
    end
    gid = -1;
    if (budget >= 3000) begin
      chk("accept_timeout", 0, 1);
    end else begin
      eg = (v0 && v1) ? ((m_last == 1) ? 0 : 1) : (v1 ? 1 : 0);
      chk("grant", {30'd0, req1_ready, req0_ready}, (eg == 1) ? 2 : 1);
      if (we && wm >= 1 && wm <= 32) m_mod = wm;
      x = (eg == 1) ? x1 : x0;
      e.id = eg; e.xm = ref_mod(x, m_mod); e.lat = ref_lat(x, m_mod); e.acyc = cyc;
      sbq.push_back(e);
      m_last = eg;
      gid = eg;
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic cfg(input int m, input bit dut_idle);
    cfg_we = 1'b1; cfg_modulus = m[7:0];
    if (dut_idle && m >= 1 && m <= 32) m_mod = m;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while ((sbq.size() != 0 || res_valid) && b < 3000) begin
      @(negedge clk); b++;
    end
    if (b >= 3000) chk("drain_timeout", 0, 1);
  endtask

  // Monitor: pops the scoreboard on each new result and polices the hold window.
  bit   first = 1'b1;
  int   stall_left = 0;
  int   cap_x = 0, cap_id = 0;
  exp_t me;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      first = 1'b1; res_ready = 1'b0;
    end else if (res_valid) begin
      if (first) begin
        first = 1'b0;
        if (sbq.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          me = sbq.pop_front();
          chk("x_mod", int'(x_mod), me.xm);
          chk("res_id", int'(res_id), me.id);
          chk("latency", cyc - me.acyc - 1, me.lat);
        end
        cap_x = int'(x_mod); cap_id = int'(res_id);
        stall_left = stall_req;
      end else begin
        chk("hold_x_mod", int'(x_mod), cap_x);
        chk("hold_res_id", int'(res_id), cap_id);
        chk("hold_no_ready", int'(req0_ready | req1_ready), 0);
      end
      if (stall_left > 0) begin
        res_ready = 1'b0; stall_left--;
      end else begin
        res_ready = 1'b1;
      end
    end else begin
      first = 1'b1; res_ready = 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, x0, x1, v;
    int b0;
    int xs[5];
    xs = '{-1, -2, -3, 3, 30};
    b0 = 0;

    req0_valid = 1'b1; req1_valid = 1'b1;
    #3;
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_x_mod", int'(x_mod), 0);
    chk("rst_res_id", int'(res_id), 0);
    chk("rst_ready", int'(req0_ready | req1_ready), 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (xs[i]) issue(1'b1, xs[i], 1'b0, 0, 1'b0, 0, g);
    wait_drain();

    for (int i = 0; i < 4; i++) issue(1'b1, 5, 1'b1, -5, 1'b0, 0, g);
    wait_drain();

    stall_req = 10;
    issue(1'b1, 7, 1'b0, 0, 1'b0, 0, g);
    issue(1'b0, 0, 1'b1, 9, 1'b0, 0, g);
    stall_req = 0;
    wait_drain();

    cfg(40, 1'b1);
    issue(1'b1, 30, 1'b0, 0, 1'b0, 0, g);
    cfg(7, 1'b0);
    wait_drain();
    issue(1'b1, 30, 1'b0, 0, 1'b0, 0, g);
    wait_drain();
    cfg(7, 1'b1);
    issue(1'b1, 30, 1'b0, 0, 1'b0, 0, g);
    issue(1'b1, 30, 1'b0, 0, 1'b1, 17, g);
    wait_drain();

    cfg(1, 1'b1);
`ifdef MOD_SCHED_BUSYCNT_EN
    b0 = int'(busy_cycles);
`endif
    issue(1'b1, -128, 1'b0, 0, 1'b0, 0, g);
    wait_drain();
`ifdef MOD_SCHED_BUSYCNT_EN
    chk("busy_cycles", int'(busy_cycles) - b0, 129);
`endif

    issue(1'b1, -128, 1'b0, 0, 1'b0, 0, g);
    repeat (20) @(negedge clk);
    #3;
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("midrun_rst_ready", int'(req0_ready | req1_ready), 0);
    chk("midrun_rst_res_valid", int'(res_valid), 0);
    chk("midrun_rst_x_mod", int'(x_mod), 0);
    sbq.delete();
    m_mod = 17; m_last = 1;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("post_rst_no_result", int'(res_valid), 0);
    issue(1'b1, 30, 1'b1, -30, 1'b0, 0, g);
    wait_drain();

    for (int i = 0; i < 80; i++) begin
      stall_req = $urandom_range(0, 2);
      v = $urandom_range(1, 3);
      x0 = int'($urandom_range(0, 255)) - 128;
      x1 = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 3) == 0)
        issue(v[0], x0, v[1], x1, 1'b1, int'($urandom_range(0, 40)), g);
      else
        issue(v[0], x0, v[1], x1, 1'b0, 0, g);
    end
    stall_req = 0;
    wait_drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
